// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants for the keypad emulator.
//  KEY_ROW/KEY_COL : 2-bit row/column index per hex code (0 = R1/C1 .. 3 = R4/C4)
//  ROW_IDLE        : all rows released (active-low lines)
//  state_t         : emulator FSM states
//  row_drive()     : row response for one held key given the current column drive
package keypad_pkg;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  //                              0     1     2     3     4     5     6     7
  //                              8     9     A     B     C     D     E     F
  localparam logic [1:0] KEY_ROW [16] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                          2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  localparam logic [1:0] KEY_COL [16] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0,
                                          2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // R1/C1 sit on bit 3, so bit position = 3 - index, which for a 2-bit index is ~index.
  // Only the key's own column is looked at; other low columns never pull a row.
  function automatic logic [3:0] row_drive(input logic [3:0] code, input logic [3:0] col);
    logic [3:0] r;
    r = ROW_IDLE;
    if (!col[~KEY_COL[code]]) r[~KEY_ROW[code]] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/keypad_emulator_fifo.sv
// key_fifo: small key-code queue.
//  push/din   : write when !full
//  pop/dout   : dout is the head; pop advances when !empty
//  flush      : empties the queue on the next edge (wins over push/pop)
//  full/empty : derived from wrap-bit pointer compare
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [3:0] din,
  input  logic       pop,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [3:0]  mem [DEPTH];
  logic [AW:0] wp, rp;
  logic        do_push, do_pop;

  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is read until a push has written it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: answers a column-scanning keypad decoder on the Row lines,
// replaying queued hex key codes as timed press/release events.
//  clk, rst_n          : clock, async active-low reset
//  key_code/key_valid  : queue input, transfer when key_valid & key_ready
//  key_ready           : queue not full
//  abort               : flush queue and release the key on the next edge
//  Col                 : column drive (active-low, C1 = Col[3])
//  Row                 : registered row response (active-low, R1 = Row[3])
//  pressed/pressed_code: currently held key
//  key_done            : one-cycle pulse at the end of each completed hold
//  busy                : queue non-empty or FSM active
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 2_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       abort,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       pressed,
  output logic [3:0] pressed_code,
  output logic       key_done,
  output logic       busy
);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state;
  logic [CW-1:0] cnt, cnt_inc;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [3:0]    head;

  assign key_ready = !fifo_full;
  // abort drops any key offered in the same cycle
  assign fifo_push = key_valid && !fifo_full && !abort;
  assign fifo_pop  = (state == IDLE) && !fifo_empty && !abort;
  assign busy      = !fifo_empty || (state != IDLE);
  // saturate rather than wrap
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (fifo_push),
    .din   (key_code),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Row is computed from the same decision that sets pressed, so Row is never
  // pulled low in a cycle where pressed reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pressed      <= 1'b0;
      pressed_code <= 4'h0;
      key_done     <= 1'b0;
      Row          <= ROW_IDLE;
    end else begin
      key_done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        cnt     <= '0;
        pressed <= 1'b0;
        Row     <= ROW_IDLE;
      end else begin
        case (state)
          IDLE: begin
            Row <= ROW_IDLE;
            if (!fifo_empty) begin
              pressed_code <= head;
              pressed      <= 1'b1;
              cnt          <= '0;
              Row          <= row_drive(head, Col);
              state        <= PRESS;
            end
          end
          PRESS: begin
            if (cnt == HOLD_LAST) begin
              pressed  <= 1'b0;
              key_done <= 1'b1;
              cnt      <= '0;
              Row      <= ROW_IDLE;
              state    <= (GAP_CYCLES > 0) ? RELEASE : IDLE;
            end else begin
              cnt <= cnt_inc;
              Row <= row_drive(pressed_code, Col);
            end
          end
          RELEASE: begin
            Row <= ROW_IDLE;
            if (cnt == GAP_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            Row   <= ROW_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;
  localparam int HOLD = 20;
  localparam int GAP  = 5;
  localparam int PER  = HOLD + GAP + 1;  // hold + release + one IDLE pop cycle

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] Col = 4'hF;
  logic       key_ready, pressed, key_done, busy;
  logic [3:0] Row, pressed_code;

  logic [3:0] b_key_code = 4'h0;
  logic       b_key_valid = 1'b0;
  logic       b_abort = 1'b0;
  logic [3:0] b_Col = 4'hF;
  logic       b_key_ready, b_pressed, b_key_done, b_busy;
  logic [3:0] b_Row, b_pressed_code;

  keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .abort(abort), .Col(Col), .Row(Row), .pressed(pressed),
    .pressed_code(pressed_code), .key_done(key_done), .busy(busy)
  );

  keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_code(b_key_code), .key_valid(b_key_valid),
    .key_ready(b_key_ready), .abort(b_abort), .Col(b_Col), .Row(b_Row), .pressed(b_pressed),
    .pressed_code(b_pressed_code), .key_done(b_key_done), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int done_cnt = 0;
  always @(negedge clk) if (key_done) done_cnt++;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  logic [3:0] codes [4] = '{4'h1, 4'hF, 4'hE, 4'hD};
  logic [3:0] scan  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [3:0] ecol  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [3:0] erow  [4] = '{4'b0111, 4'b1110, 4'b1110, 4'b1110};
  int d0, rowbad, prbad, codebad, row1011, k, ph;
  logic       exp_p;
  logic [3:0] exp_r;

  initial begin
    // ---- reset state
    tick(2);
    chk4("rst_row", Row, 4'b1111);
    chk1("rst_pressed", pressed, 1'b0);
    chk1("rst_ready", key_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", key_done, 1'b0);
    chk4("rst_code", pressed_code, 4'h0);
    rst_n = 1'b1;
    tick(2);

    // ---- 1: key 5 (R2C2)
    d0 = done_cnt;
    Col = 4'b1011; key_code = 4'h5; key_valid = 1'b1;
    tick(1);                          // push edge
    key_valid = 1'b0;
    chk1("t1_not_yet", pressed, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    tick(1);                          // pop edge, hold cycle 1
    chk1("t1_pressed", pressed, 1'b1);
    chk4("t1_code", pressed_code, 4'h5);
    row1011 = 0;
    for (int i = 0; i < 9; i++) begin
      if (Row !== 4'b1011) row1011++;
      tick(1);
    end
    if (Row !== 4'b1011) row1011++;
    chkn("t1_row_held", row1011, 0);
    Col = 4'b0111;
    tick(1);                          // hold cycle 11
    chk4("t1_row_othercol", Row, 4'b1111);
    tick(9);                          // hold cycle 20
    chk1("t1_last_hold", pressed, 1'b1);
    tick(1);
    chk1("t1_released", pressed, 1'b0);
    chk1("t1_done_pulse", key_done, 1'b1);
    tick(1);
    chk1("t1_done_low", key_done, 1'b0);
    chkn("t1_done_count", done_cnt - d0, 1);
    tick(3);
    chk1("t1_busy_gap", busy, 1'b1);
    tick(1);                          // gap done, back to IDLE
    chk1("t1_idle", busy, 1'b0);

    // ---- 2: 1,F,E,D under a rotating column scan
    d0 = done_cnt; rowbad = 0; prbad = 0; codebad = 0;
    for (int j = 0; j <= 4 * PER; j++) begin
      Col = scan[j % 4];
      key_valid = (j < 4);
      key_code = codes[(j < 4) ? j : 0];
      tick(1);
      k = (j >= 1) ? (j - 1) / PER : 0;
      ph = (j >= 1) ? (j - 1) % PER : PER;
      exp_p = (j >= 1) && (ph < HOLD) && (k < 4);
      exp_r = (exp_p && (scan[j % 4] == ecol[k])) ? erow[k] : 4'b1111;
      if (Row !== exp_r) rowbad++;
      if (pressed !== exp_p) prbad++;
      if (exp_p && (pressed_code !== codes[k])) codebad++;
    end
    key_valid = 1'b0;
    chkn("t2_row_scan", rowbad, 0);
    chkn("t2_pressed_windows", prbad, 0);
    chkn("t2_code_order", codebad, 0);
    chkn("t2_done_count", done_cnt - d0, 4);
    chk1("t2_idle", busy, 1'b0);

    // ---- 3: fill the queue behind a held key
    Col = 4'b1110;
    key_valid = 1'b1; key_code = 4'h2;
    tick(1);                          // e0 push 2
    key_code = 4'hA; tick(1);         // e1 pop 2, push A
    key_code = 4'hB; tick(1);
    key_code = 4'hC; tick(1);
    key_code = 4'h7; tick(1);         // e4 queue A,B,C,7
    chk1("t3_full", key_ready, 1'b0);
    key_code = 4'h8; tick(1);         // e5 dropped
    key_valid = 1'b0;
    chk1("t3_still_full", key_ready, 1'b0);
    tick(21);                         // e26 still in gap
    chk1("t3_full_gap", key_ready, 1'b0);
    tick(1);                          // e27 pop A
    chk1("t3_slot_freed", key_ready, 1'b1);
    chk4("t3_head_A", pressed_code, 4'hA);
    tick(PER);                        // e53 pop B
    chk4("t3_head_B", pressed_code, 4'hB);
    chk4("t3_row_B", Row, 4'b1011);

    // ---- 4: abort at hold cycle 10 of B, with C,7 queued
    tick(8);                          // e61
    chk1("t4_pre_abort", pressed, 1'b1);
    d0 = done_cnt;
    abort = 1'b1; key_valid = 1'b1; key_code = 4'h3;
    tick(1);                          // e62
    abort = 1'b0; key_valid = 1'b0;
    chk4("t4_row", Row, 4'b1111);
    chk1("t4_pressed", pressed, 1'b0);
    chk1("t4_busy", busy, 1'b0);
    tick(30);
    chkn("t4_no_done", done_cnt - d0, 0);
    chk1("t4_stays_idle", busy, 1'b0);

    // ---- 5: async reset mid-press
    Col = 4'b1101; key_valid = 1'b1; key_code = 4'h6;
    tick(1);
    key_code = 4'h7; tick(1);         // 6 held, 7 queued
    key_valid = 1'b0;
    chk4("t5_row_6", Row, 4'b1011);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk4("t5_async_row", Row, 4'b1111);
    chk1("t5_async_pressed", pressed, 1'b0);
    chk1("t5_async_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk1("t5_after_busy", busy, 1'b0);
    tick(3);
    chk1("t5_queue_empty", pressed, 1'b0);

    // ---- 6a: all columns low, key 9 (R3C3) pulls only R3
    Col = 4'b0000; key_valid = 1'b1; key_code = 4'h9;
    tick(1);
    key_valid = 1'b0;
    tick(1);
    chk4("t6_multicol", Row, 4'b1101);
    abort = 1'b1; tick(1); abort = 1'b0;

    // ---- 6b: GAP=0 build, 2 then 3
    b_key_valid = 1'b1; b_key_code = 4'h2;
    tick(1);                          // e0
    b_key_code = 4'h3; tick(1);       // e1 pop 2, push 3
    b_key_valid = 1'b0;
    chk1("t6b_p2", b_pressed, 1'b1);
    chk4("t6b_code2", b_pressed_code, 4'h2);
    tick(19);                         // e20
    chk1("t6b_hold_end", b_pressed, 1'b1);
    tick(1);                          // e21 the single idle cycle
    chk1("t6b_idle_gap", b_pressed, 1'b0);
    chk1("t6b_done", b_key_done, 1'b1);
    tick(1);                          // e22
    chk1("t6b_p3", b_pressed, 1'b1);
    chk4("t6b_code3", b_pressed_code, 4'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
